// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the pwm ramp sequencer and its helpers.
package pwm_pkg;

  localparam int COUNTER_WIDTH  = 8;
  localparam int INTERVAL_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Ramp command channel between the register/CPU side (master) and the sequencer (slave).
// Handshake: a command transfers on a rising clk edge where cmd_valid & cmd_ready are both 1;
// once cmd_valid is raised the master holds it and every field stable until that transfer.
interface pwm_ramp_ctrl_if #(
  parameter int W  = pwm_pkg::COUNTER_WIDTH,
  parameter int IW = pwm_pkg::INTERVAL_WIDTH
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_target;
  logic [W-1:0]  cmd_step;
  logic [IW-1:0] cmd_ivl;

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_ivl,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_ivl,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_period_tracker.sv
// Shadow of the pwm counter: advances while enabled and flags the last cycle of each period.
module pwm_period_tracker #(
  parameter int W = pwm_pkg::COUNTER_WIDTH
) (
  input  logic         clk_i,
  input  logic         a_rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         pb_o
);

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

  // Updating the compare value in this cycle makes it live from counter value 0.
  assign pb_o = en_i & (cnt_o == {W{1'b1}});

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for one pwm channel: accepts target/step/interval commands and walks the
// compare value toward the target, touching it only at period boundaries.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH  = pwm_pkg::COUNTER_WIDTH,
  parameter int INTERVAL_WIDTH = pwm_pkg::INTERVAL_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     a_rst_i,
  input  logic                     run_i,
  input  logic                     abort_i,
  pwm_ramp_ctrl_if.slave           cmd,
  output logic                     pwm_en_o,
  output logic [COUNTER_WIDTH-1:0] duty_o,
  output logic                     busy_o,
  output logic                     done_o,
  output state_t                   state_o
);

  localparam int W  = COUNTER_WIDTH;
  localparam int IW = INTERVAL_WIDTH;

  state_t        state_q, state_d;
  logic [W-1:0]  duty_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  step_q, step_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [IW-1:0] ivl_cnt_q, ivl_cnt_d;
  logic          done_d;
  logic [W:0]    diff;
  logic          pb;
  logic [W-1:0]  shadow_cnt;

  pwm_period_tracker #(.W(W)) u_tracker (
    .clk_i   (clk_i),
    .a_rst_i (a_rst_i),
    .en_i    (pwm_en_o),
    .cnt_o   (shadow_cnt),
    .pb_o    (pb)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy_o        = (state_q == ST_RAMP);
  assign state_o       = state_q;

  // Distance to target in W+1 bits so the comparison with step can never overflow.
  always_comb begin
    if (target_q >= duty_o) begin
      diff = {1'b0, target_q} - {1'b0, duty_o};
    end else begin
      diff = {1'b0, duty_o} - {1'b0, target_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_o;
    target_d  = target_q;
    step_d    = step_q;
    ivl_d     = ivl_q;
    ivl_cnt_d = ivl_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          target_d  = cmd.cmd_target;
          step_d    = cmd.cmd_step;
          ivl_d     = cmd.cmd_ivl;
          ivl_cnt_d = cmd.cmd_ivl;
          state_d   = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (pb) begin
          if (ivl_cnt_q != '0) begin
            ivl_cnt_d = ivl_cnt_q - 1'b1;
          end else begin
            ivl_cnt_d = ivl_q;
            if ((step_q == '0) || (diff <= {1'b0, step_q})) begin
              duty_d  = target_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (target_q > duty_o) begin
              duty_d = duty_o + step_q;
            end else begin
              duty_d = duty_o - step_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q   <= ST_IDLE;
      duty_o    <= '0;
      target_q  <= '0;
      step_q    <= '0;
      ivl_q     <= '0;
      ivl_cnt_q <= '0;
      done_o    <= 1'b0;
      pwm_en_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_o    <= duty_d;
      target_q  <= target_d;
      step_q    <= step_d;
      ivl_q     <= ivl_d;
      ivl_cnt_q <= ivl_cnt_d;
      done_o    <= done_d;
      pwm_en_o  <= run_i;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, shadow_cnt};

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: vector table of ramp commands plus hand-written
// sequences for abort, run freeze, asynchronous reset and held-off commands.
module tb_pwm_ramp_ctrl;
  import pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       pwm_en;
  logic [7:0] duty;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  pwm_ramp_ctrl_if #(.W(8), .IW(8)) cmd_if ();

  pwm_ramp_ctrl #(.COUNTER_WIDTH(8), .INTERVAL_WIDTH(8)) dut (
    .clk_i    (clk),
    .a_rst_i  (rst),
    .run_i    (run),
    .abort_i  (abort),
    .cmd      (cmd_if.slave),
    .pwm_en_o (pwm_en),
    .duty_o   (duty),
    .busy_o   (busy),
    .done_o   (done),
    .state_o  (dbg_state)
  );

  // clock / reset / independent period model
  always #5 clk = ~clk;

  logic       m_en;
  logic [7:0] m_cnt;
  logic       m_pb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en  <= 1'b0;
      m_cnt <= 8'd0;
    end else begin
      m_en <= run;
      if (m_en) m_cnt <= m_cnt + 8'd1;
    end
  end
  assign m_pb = m_en && (m_cnt == 8'hff);

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] m_duty = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [7:0] t, input logic [7:0] s, input logic [7:0] i);
    int budget = 2000;
    @(negedge clk);
    cmd_if.cmd_target = t;
    cmd_if.cmd_step   = s;
    cmd_if.cmd_ivl    = i;
    cmd_if.cmd_valid  = 1'b1;
    while (!cmd_if.cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("accept_timeout", (budget > 0), 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_pbs(input int n);
    int left = n;
    int budget = n * 300 + 10;
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_pb) begin
        @(posedge clk);
        #1;
        left--;
      end
    end
    check("pb_wait_timeout", (left == 0), 1);
  endtask

  typedef struct packed {
    logic [7:0]      target;
    logic [7:0]      step;
    logic [7:0]      ivl;
    logic [2:0]      n;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int d0;
    send_cmd(v.target, v.step, v.ivl);
    d0 = done_cnt;
    for (int k = 0; k < int'(v.n); k++) exp_q.push_back(v.exp[k]);
    for (int k = 0; k < int'(v.n); k++) begin
      logic [7:0] e;
      if (v.ivl != 8'd0) begin
        wait_pbs(int'(v.ivl));
        check("duty_hold_ivl", duty, m_duty);
      end
      wait_pbs(1);
      e = exp_q.pop_front();
      check("duty_step", duty, e);
      check("done_flag", done, (k == int'(v.n) - 1));
      m_duty = e;
    end
    check("busy_end", busy, 0);
    check("ready_end", cmd_if.cmd_ready, 1);
    @(posedge clk);
    #1;
    check("done_pulse_len", done, 0);
    check("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int budget;
    int stable;
    int d0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = 8'd0;
    cmd_if.cmd_step   = 8'd0;
    cmd_if.cmd_ivl    = 8'd0;

    vecs[0] = '{target: 8'd100, step: 8'd25,  ivl: 8'd0, n: 3'd4, exp: {8'd100, 8'd75, 8'd50, 8'd25}};
    vecs[1] = '{target: 8'd10,  step: 8'd40,  ivl: 8'd1, n: 3'd3, exp: {8'd0, 8'd10, 8'd20, 8'd60}};
    vecs[2] = '{target: 8'd0,   step: 8'd0,   ivl: 8'd0, n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[3] = '{target: 8'd255, step: 8'd200, ivl: 8'd0, n: 3'd2, exp: {8'd0, 8'd0, 8'd255, 8'd200}};
    vecs[4] = '{target: 8'd0,   step: 8'd0,   ivl: 8'd0, n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{target: 8'd255, step: 8'd0,   ivl: 8'd0, n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd255}};
    vecs[6] = '{target: 8'd255, step: 8'd7,   ivl: 8'd2, n: 3'd1, exp: {8'd0, 8'd0, 8'd0, 8'd255}};

    #1;
    check("rst_duty", duty, 0);
    check("rst_en", pwm_en, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;
    check("en_follows_run", pwm_en, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // abort coincident with a period boundary
    send_cmd(8'd0, 8'd50, 8'd0);
    wait_pbs(1);
    check("abort_pre_step", duty, 205);
    m_duty = 8'd205;
    d0 = done_cnt;
    budget = 300;
    do begin
      @(negedge clk);
      budget--;
    end while (!m_pb && budget > 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_duty_held", duty, 205);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_if.cmd_ready, 1);
    check("abort_no_done", done, 0);
    wait_pbs(1);
    check("abort_duty_after", duty, 205);
    check("abort_done_never", done_cnt - d0, 0);

    // run_i freeze mid-ramp
    send_cmd(8'd5, 8'd100, 8'd0);
    wait_pbs(1);
    check("freeze_pre", duty, 105);
    repeat (100) @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    check("freeze_en_low", pwm_en, 0);
    stable = 1;
    repeat (600) begin
      @(negedge clk);
      if (duty !== 8'd105 || pwm_en !== 1'b0 || busy !== 1'b1) stable = 0;
    end
    check("freeze_stable", stable, 1);
    run = 1'b1;
    @(posedge clk);
    #1;
    check("resume_en", pwm_en, 1);
    wait_pbs(1);
    check("resume_duty", duty, 5);
    check("resume_done", done, 1);

    // asynchronous reset mid-ramp
    send_cmd(8'd200, 8'd10, 8'd0);
    wait_pbs(1);
    check("prerst_duty", duty, 15);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_duty", duty, 0);
    check("arst_en", pwm_en, 0);
    check("arst_ready", cmd_if.cmd_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // command held off during a ramp is accepted one cycle after done_o
    send_cmd(8'd30, 8'd15, 8'd0);
    @(negedge clk);
    cmd_if.cmd_target = 8'd0;
    cmd_if.cmd_step   = 8'd0;
    cmd_if.cmd_ivl    = 8'd0;
    cmd_if.cmd_valid  = 1'b1;
    wait_pbs(1);
    check("held_step1", duty, 15);
    check("held_ready_low", cmd_if.cmd_ready, 0);
    check("held_busy", busy, 1);
    wait_pbs(1);
    check("held_step2", duty, 30);
    check("held_done", done, 1);
    check("held_ready_at_done", cmd_if.cmd_ready, 1);
    check("held_busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check("held_accepted_busy", busy, 1);
    check("held_accepted_ready", cmd_if.cmd_ready, 0);
    check("held_done_cleared", done, 0);
    wait_pbs(1);
    check("held_jump", duty, 0);
    check("held_jump_done", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
